// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the core's data-memory interface. Accepts one read or write
// request at a time, answers it with a single-cycle response pulse LAT cycles
// after acceptance, and flags misaligned or out-of-range addresses.
//
// Parameters:
//   DEPTH  number of 32-bit words (power of two, 2..1024)
//   LAT    cycles from request acceptance to response (1..8)
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_req        request valid
//   i_wen        1 = write, 0 = read; sampled with i_req
//   i_addr       byte address
//   i_wdata      write data
//   o_ready      responder can accept a request this cycle
//   o_rvalid     response valid, one-cycle pulse
//   o_rdata      read data, valid with o_rvalid (0 for writes and errors)
//   o_err        access error, valid with o_rvalid
//   o_dbg_state  current FSM state (IDLE=0, WAIT=1, RESP=2) for observation
//
// Optional feature (macro DMEM_ACCESS_CNT_EN):
//   o_rd_cnt, o_wr_cnt, o_err_cnt  saturating 16-bit access counters,
//   incremented at the accept edge of reads, writes and errored accesses.
//
// Handshake: a request transfers on a rising edge where i_req=1 and o_ready=1.
// o_ready is high only in IDLE and never while i_rst is asserted; while it is
// low, i_req/i_wen/i_addr/i_wdata are ignored. The requester need not hold
// anything after the transfer edge. o_rvalid is a one-cycle pulse with no
// back-pressure; it is high in the cycle following edge (accept + LAT).
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_wen,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic [1:0]  o_dbg_state
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0] o_rd_cnt,
    output logic [15:0] o_wr_cnt,
    output logic [15:0] o_err_cnt
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);
    localparam logic [2:0]  CNT_INIT = 3'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [2:0]     cnt;
    logic           wen_q;
    logic           err_q;
    logic [AW-1:0]  idx_q;
    logic [31:0]    mem [DEPTH];

    logic [AW-1:0]  req_idx;
    logic           req_err;
    logic           accept;

    // Full 32-bit range compare, so high addresses never alias onto low words.
    assign req_idx = i_addr[AW+1:2];
    assign req_err = (i_addr[1:0] != 2'b00) || (i_addr >= LIMIT);

    // Gating with i_rst keeps o_ready low for the whole reset interval and
    // lets it rise in the very first cycle after reset is released.
    assign o_ready     = (state == IDLE) && !i_rst;
    assign accept      = o_ready && i_req;
    assign o_dbg_state = state;

    // The response outputs are registered off the RESP state, which puts the
    // o_rvalid pulse in the cycle after edge (accept + LAT) and lets IDLE
    // (and a new acceptance) coincide with that pulse: one request per LAT+1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wen_q <= i_wen;
                        err_q <= req_err;
                        idx_q <= req_idx;
                        // Writes commit at the accept edge; errored writes are dropped.
                        if (i_wen && !req_err) begin
                            mem[req_idx] <= i_wdata;
                        end
                        if (LAT == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    o_rvalid <= 1'b1;
                    o_err    <= err_q;
                    o_rdata  <= (!wen_q && !err_q) ? mem[idx_q] : 32'd0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    // An errored write counts as a write and as an error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_cnt  <= '0;
            o_wr_cnt  <= '0;
            o_err_cnt <= '0;
        end else if (accept) begin
            if (!i_wen && o_rd_cnt != 16'hFFFF) begin
                o_rd_cnt <= o_rd_cnt + 16'd1;
            end
            if (i_wen && o_wr_cnt != 16'hFFFF) begin
                o_wr_cnt <= o_wr_cnt + 16'd1;
            end
            if (req_err && o_err_cnt != 16'hFFFF) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
